// File: rtl/sramlike_axi_xbar_pkg.sv
// Shared definitions for the sram-like to AXI3 crossbar.
// Contents: AXI burst/resp constants, sram-like size encodings, read and
// write FSM state encodings, and the write-strobe helper function.
package sramlike_axi_xbar_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // Byte-lane strobe for a single-beat write of the given size at the
    // given low address bits. Unknown size codes fall back to a full word.
    function automatic logic [3:0] wstrb_of(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addr_lo;
            SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sramlike_axi_xbar_rr_arbiter.sv
// Round-robin arbiter.
// Ports: clk/rst_n (async active-low), req (request vector), advance
// (move the pointer to the current winner), grant (one-hot, combinational),
// idx (binary index of the winner). The search starts one past the last
// granted index and wraps; the pointer resets to 0.
module sramlike_axi_xbar_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr_r;

    // Pick the first requester after the pointer, wrapping around.
    always_comb begin
        int  cand;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_r) + k) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end else begin
                found = found;
            end
        end
    end

    // Pointer follows the winner only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= idx;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/sramlike_axi_xbar.sv
// Crossbar from NUM_PORTS sram-like masters onto one AXI3 master port.
// Ports: aclk/aresetn; per-port request bundle (port_req/wr/size/len/addr/
// wdata) with port_addr_ok/port_data_ok handshakes and a shared port_rdata;
// sticky bus_err; full AXI3 ar/r/aw/w/b master channels (4-bit ids/len).
// One read burst and one single-beat write may be in flight together; a read
// to the line of the outstanding write is held back until the write's B
// response arrives. The port index is used as the AXI id.
module sramlike_axi_xbar
    import sramlike_axi_xbar_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int HAZ_LSB   = 5
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NUM_PORTS-1:0]   port_req,
    input  logic [NUM_PORTS-1:0]   port_wr,
    input  logic [2*NUM_PORTS-1:0] port_size,
    input  logic [4*NUM_PORTS-1:0] port_len,
    input  logic [32*NUM_PORTS-1:0] port_addr,
    input  logic [32*NUM_PORTS-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]   port_addr_ok,
    output logic [NUM_PORTS-1:0]   port_data_ok,
    output logic [31:0]            port_rdata,
    output logic                   bus_err,
    output logic [3:0]             arid,
    output logic [31:0]            araddr,
    output logic [3:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic [1:0]             arlock,
    output logic [3:0]             arcache,
    output logic [2:0]             arprot,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [3:0]             rid,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    output logic [3:0]             awid,
    output logic [31:0]            awaddr,
    output logic [3:0]             awlen,
    output logic [2:0]             awsize,
    output logic [1:0]             awburst,
    output logic [1:0]             awlock,
    output logic [3:0]             awcache,
    output logic [2:0]             awprot,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [3:0]             wid,
    output logic [31:0]            wdata,
    output logic [3:0]             wstrb,
    output logic                   wlast,
    output logic                   wvalid,
    input  logic                   wready,
    input  logic [3:0]             bid,
    input  logic [1:0]             bresp,
    input  logic                   bvalid,
    output logic                   bready
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int HW = 32 - HAZ_LSB;

    r_state_e r_state_r, r_state_s;
    w_state_e w_state_r, w_state_s;

    logic [NUM_PORTS-1:0] busy_r;
    logic [NUM_PORTS-1:0] haz_s, r_elig_s, w_elig_s;
    logic [NUM_PORTS-1:0] r_grant_s, w_grant_s;
    logic [NUM_PORTS-1:0] rd_ok_s, wr_ok_s, rd_clr_s;
    logic [IW-1:0]        r_gidx_s, w_gidx_s;

    logic [31:0] r_addr_r;
    logic [1:0]  r_size_r;
    logic [3:0]  r_len_r;
    logic [3:0]  r_id_r;
    logic        arvalid_r, rready_r;

    logic [31:0] w_addr_r, w_data_r;
    logic [1:0]  w_size_r;
    logic [3:0]  w_id_r, w_strb_r;
    logic        aw_pend_r, w_pend_r, bready_r;

    logic        bus_err_r;
    logic        r_beat_s, r_last_s, b_done_s, aw_done_s, w_done_s;

    // Response ids are redundant with the latched owner ids.
    logic        unused_ids_s;
    assign unused_ids_s = ^{rid, bid};

    assign r_beat_s  = rready_r && rvalid;
    assign r_last_s  = r_beat_s && rlast;
    assign b_done_s  = bready_r && bvalid;
    assign aw_done_s = !aw_pend_r || awready;
    assign w_done_s  = !w_pend_r || wready;

    // Per-port eligibility: idle FSM, not busy, and for reads no line hazard.
    always_comb begin
        haz_s    = '0;
        r_elig_s = '0;
        w_elig_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            haz_s[i]    = (w_state_r != W_IDLE) &&
                          (port_addr[i*32+HAZ_LSB +: HW] == w_addr_r[31:HAZ_LSB]);
            r_elig_s[i] = (r_state_r == R_IDLE) && port_req[i] && !port_wr[i] &&
                          !busy_r[i] && !haz_s[i];
            w_elig_s[i] = (w_state_r == W_IDLE) && port_req[i] && port_wr[i] &&
                          !busy_r[i];
        end
    end

    sramlike_axi_xbar_rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rd_arb (
        .clk     (aclk),
        .rst_n   (aresetn),
        .req     (r_elig_s),
        .advance (|r_elig_s),
        .grant   (r_grant_s),
        .idx     (r_gidx_s)
    );

    sramlike_axi_xbar_rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_wr_arb (
        .clk     (aclk),
        .rst_n   (aresetn),
        .req     (w_elig_s),
        .advance (|w_elig_s),
        .grant   (w_grant_s),
        .idx     (w_gidx_s)
    );

    // Route read beats and write completions to the owning port.
    always_comb begin
        rd_ok_s  = '0;
        wr_ok_s  = '0;
        rd_clr_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_ok_s[i]  = r_beat_s && (r_id_r == 4'(i));
            wr_ok_s[i]  = b_done_s && (w_id_r == 4'(i));
            rd_clr_s[i] = r_last_s && (r_id_r == 4'(i));
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: if (|r_grant_s) r_state_s = R_AR;   else r_state_s = R_IDLE;
            R_AR:   if (arready)    r_state_s = R_DATA; else r_state_s = R_AR;
            R_DATA: if (r_last_s)   r_state_s = R_IDLE; else r_state_s = R_DATA;
            default:                r_state_s = R_IDLE;
        endcase
    end

    // Write FSM next state; address and data phases may finish in any order.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: if (|w_grant_s)             w_state_s = W_SEND; else w_state_s = W_IDLE;
            W_SEND: if (aw_done_s && w_done_s)  w_state_s = W_RESP; else w_state_s = W_SEND;
            W_RESP: if (b_done_s)               w_state_s = W_IDLE; else w_state_s = W_RESP;
            default:                            w_state_s = W_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_r <= R_IDLE;
            w_state_r <= W_IDLE;
        end else begin
            r_state_r <= r_state_s;
            w_state_r <= w_state_s;
        end
    end

    // Read channel: latch the granted request and drive AR/R handshakes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr_r  <= 32'h0000_0000;
            r_size_r  <= 2'b00;
            r_len_r   <= 4'h0;
            r_id_r    <= 4'h0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else begin
            if (r_state_r == R_IDLE && |r_grant_s) begin
                r_addr_r  <= port_addr[int'(r_gidx_s)*32 +: 32];
                r_size_r  <= port_size[int'(r_gidx_s)*2 +: 2];
                r_len_r   <= port_len[int'(r_gidx_s)*4 +: 4];
                r_id_r    <= 4'(r_gidx_s);
                arvalid_r <= 1'b1;
            end else if (arvalid_r && arready) begin
                arvalid_r <= 1'b0;
            end else begin
                arvalid_r <= arvalid_r;
            end
            if (arvalid_r && arready) begin
                rready_r <= 1'b1;
            end else if (r_last_s) begin
                rready_r <= 1'b0;
            end else begin
                rready_r <= rready_r;
            end
        end
    end

    // Write channel: latch the granted request; AW and W retire independently.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_addr_r  <= 32'h0000_0000;
            w_data_r  <= 32'h0000_0000;
            w_size_r  <= 2'b00;
            w_id_r    <= 4'h0;
            w_strb_r  <= 4'h0;
            aw_pend_r <= 1'b0;
            w_pend_r  <= 1'b0;
            bready_r  <= 1'b0;
        end else begin
            if (w_state_r == W_IDLE && |w_grant_s) begin
                w_addr_r  <= port_addr[int'(w_gidx_s)*32 +: 32];
                w_data_r  <= port_wdata[int'(w_gidx_s)*32 +: 32];
                w_size_r  <= port_size[int'(w_gidx_s)*2 +: 2];
                w_id_r    <= 4'(w_gidx_s);
                w_strb_r  <= wstrb_of(port_size[int'(w_gidx_s)*2 +: 2],
                                      port_addr[int'(w_gidx_s)*32 +: 2]);
                aw_pend_r <= 1'b1;
                w_pend_r  <= 1'b1;
            end else begin
                aw_pend_r <= aw_pend_r && !awready;
                w_pend_r  <= w_pend_r && !wready;
            end
            if (w_state_r == W_SEND && w_state_s == W_RESP) begin
                bready_r <= 1'b1;
            end else if (b_done_s) begin
                bready_r <= 1'b0;
            end else begin
                bready_r <= bready_r;
            end
        end
    end

    // Busy tracking and sticky error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy_r    <= '0;
            bus_err_r <= 1'b0;
        end else begin
            busy_r    <= (busy_r | r_grant_s | w_grant_s) & ~rd_clr_s & ~wr_ok_s;
            bus_err_r <= bus_err_r ||
                         (r_beat_s && rresp != RESP_OKAY) ||
                         (b_done_s && bresp != RESP_OKAY);
        end
    end

    assign port_addr_ok = r_grant_s | w_grant_s;
    assign port_data_ok = rd_ok_s | wr_ok_s;
    assign port_rdata   = rdata;
    assign bus_err      = bus_err_r;

    assign arid    = r_id_r;
    assign araddr  = r_addr_r;
    assign arlen   = r_len_r;
    assign arsize  = {1'b0, r_size_r};
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;

    assign awid    = w_id_r;
    assign awaddr  = w_addr_r;
    assign awlen   = 4'b0000;
    assign awsize  = {1'b0, w_size_r};
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = aw_pend_r;
    assign wid     = w_id_r;
    assign wdata   = w_data_r;
    assign wstrb   = w_strb_r;
    assign wlast   = 1'b1;
    assign wvalid  = w_pend_r;
    assign bready  = bready_r;

endmodule

// File: tb/tb_sramlike_axi_xbar.sv
// Directed self-checking bench for sramlike_axi_xbar (two ports). The bench
// plays the AXI slave by hand; inputs change just after the falling edge and
// outputs are sampled 1 time unit later.
module tb_sramlike_axi_xbar;

    localparam int N = 2;

    logic          aclk, aresetn;
    logic [N-1:0]  port_req, port_wr;
    logic [2*N-1:0] port_size;
    logic [4*N-1:0] port_len;
    logic [32*N-1:0] port_addr, port_wdata;
    logic [N-1:0]  port_addr_ok, port_data_ok;
    logic [31:0]   port_rdata;
    logic          bus_err;
    logic [3:0]    arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0]   araddr, rdata, awaddr, wdata;
    logic [2:0]    arsize, arprot, awsize, awprot;
    logic [1:0]    arburst, arlock, rresp, awburst, awlock, bresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int tests = 0;
    int fails = 0;

    sramlike_axi_xbar #(.NUM_PORTS(N), .HAZ_LSB(5)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .port_req(port_req), .port_wr(port_wr), .port_size(port_size),
        .port_len(port_len), .port_addr(port_addr), .port_wdata(port_wdata),
        .port_addr_ok(port_addr_ok), .port_data_ok(port_data_ok),
        .port_rdata(port_rdata), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic drive(input int p, input logic req, input logic wr,
                         input logic [1:0] size, input logic [3:0] len,
                         input logic [31:0] addr, input logic [31:0] wd);
        port_req[p]          = req;
        port_wr[p]           = wr;
        port_size[p*2 +: 2]  = size;
        port_len[p*4 +: 4]   = len;
        port_addr[p*32 +: 32] = addr;
        port_wdata[p*32 +: 32] = wd;
    endtask

    initial begin
        aresetn = 1'b0;
        port_req = '0; port_wr = '0; port_size = '0; port_len = '0;
        port_addr = '0; port_wdata = '0;
        arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'h0; bresp = 2'b00; bvalid = 1'b0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid",  32'(wvalid),  32'd0);
        chk("rst_rready",  32'(rready),  32'd0);
        chk("rst_bready",  32'(bready),  32'd0);
        chk("rst_addr_ok", 32'(port_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(port_data_ok), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        aresetn = 1'b1;
        tick();

        // Port0 single-word read, AR accepted after 2 cycles
        drive(0, 1'b1, 1'b0, 2'd2, 4'd0, 32'h0000_1000, 32'h0);
        #1 chk("t1_addr_ok", 32'(port_addr_ok), 32'h1);
        tick();
        port_req[0] = 1'b0;
        #1;
        chk("t1_addr_ok_once", 32'(port_addr_ok), 32'h0);
        chk("t1_arvalid", 32'(arvalid), 32'd1);
        chk("t1_arid",    32'(arid),    32'd0);
        chk("t1_arlen",   32'(arlen),   32'd0);
        chk("t1_arsize",  32'(arsize),  32'd2);
        chk("t1_araddr",  araddr,       32'h0000_1000);
        chk("t1_arburst", 32'(arburst), 32'd1);
        tick();
        #1 chk("t1_ar_hold", 32'(arvalid), 32'd1);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1 chk("t1_ar_drop", 32'(arvalid), 32'd0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1;
        #1;
        chk("t1_data_ok", 32'(port_data_ok), 32'h1);
        chk("t1_rdata",   port_rdata,        32'hDEAD_BEEF);
        tick();
        #1;
        chk("t1_no_extra_data_ok", 32'(port_data_ok), 32'h0);
        chk("t1_rready_off", 32'(rready), 32'd0);
        rvalid = 1'b0; rlast = 1'b0;

        // Port1 8-beat burst; its held request is blocked while busy
        drive(1, 1'b1, 1'b0, 2'd2, 4'd7, 32'h0000_2000, 32'h0);
        #1 chk("t2_addr_ok", 32'(port_addr_ok), 32'h2);
        tick();
        #1;
        chk("t2_arlen", 32'(arlen), 32'd7);
        chk("t2_arid",  32'(arid),  32'd1);
        chk("t2_busy_block_ar", 32'(port_addr_ok), 32'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1; rdata = 32'h100 + 32'(k); rlast = (k == 7);
            if (k == 7) port_len[4 +: 4] = 4'd0;
            #1;
            chk($sformatf("t2_beat%0d_data_ok", k), 32'(port_data_ok), 32'h2);
            chk($sformatf("t2_beat%0d_rdata", k), port_rdata, 32'h100 + 32'(k));
            chk($sformatf("t2_beat%0d_busy", k), 32'(port_addr_ok), 32'h0);
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1 chk("t2_regrant_after_rlast", 32'(port_addr_ok), 32'h2);
        tick();
        port_req[1] = 1'b0;
        arready = 1'b1;
        #1 chk("t2_second_arlen", 32'(arlen), 32'd0);
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55;
        #1 chk("t2_second_data_ok", 32'(port_data_ok), 32'h2);
        tick();
        rvalid = 1'b0; rlast = 1'b0;

        // Round-robin from a fresh pointer: both ports request continuously
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        drive(0, 1'b1, 1'b0, 2'd2, 4'd0, 32'h0000_8000, 32'h0);
        drive(1, 1'b1, 1'b0, 2'd2, 4'd0, 32'h0000_9000, 32'h0);
        for (int t = 0; t < 4; t++) begin
            logic [1:0] exp_g;
            exp_g = (t % 2 == 0) ? 2'b10 : 2'b01;
            #1 chk($sformatf("t3_grant%0d", t), 32'(port_addr_ok), 32'(exp_g));
            tick();
            arready = 1'b1;
            #1 chk($sformatf("t3_arid%0d", t), 32'(arid), (t % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            arready = 1'b0;
            rvalid = 1'b1; rlast = 1'b1;
            #1 chk($sformatf("t3_data_ok%0d", t), 32'(port_data_ok), 32'(exp_g));
            tick();
            rvalid = 1'b0; rlast = 1'b0;
        end
        port_req = '0;

        // Byte write then a same-line read that must wait for B
        drive(0, 1'b1, 1'b1, 2'd0, 4'd0, 32'h0000_3003, 32'h0000_00AA);
        #1 chk("t4_w_addr_ok", 32'(port_addr_ok), 32'h1);
        tick();
        port_req[0] = 1'b0;
        drive(1, 1'b1, 1'b0, 2'd2, 4'd0, 32'h0000_3010, 32'h0);
        #1;
        chk("t4_wstrb",   32'(wstrb),   32'h8);
        chk("t4_awaddr",  awaddr,       32'h0000_3003);
        chk("t4_wdata",   wdata,        32'h0000_00AA);
        chk("t4_awsize",  32'(awsize),  32'd0);
        chk("t4_awlen",   32'(awlen),   32'd0);
        chk("t4_wlast",   32'(wlast),   32'd1);
        chk("t4_aw_w_valid", 32'({awvalid, wvalid}), 32'h3);
        chk("t4_hazard_send", 32'(port_addr_ok), 32'h0);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        #1 chk("t4_bready", 32'(bready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4_hazard_wait%0d", c), 32'({port_addr_ok, arvalid}), 32'h0);
            tick();
        end
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        chk("t4_b_data_ok", 32'(port_data_ok), 32'h1);
        chk("t4_hazard_on_b", 32'(port_addr_ok), 32'h0);
        tick();
        bvalid = 1'b0;
        #1 chk("t4_read_after_b", 32'(port_addr_ok), 32'h2);
        tick();
        port_req[1] = 1'b0;
        arready = 1'b1;
        #1 chk("t4_araddr", araddr, 32'h0000_3010);
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rlast = 1'b1;
        #1 chk("t4_r_data_ok", 32'(port_data_ok), 32'h2);
        tick();
        rvalid = 1'b0; rlast = 1'b0;

        // Simultaneous write (port0) and read (port1), AW before W
        drive(0, 1'b1, 1'b1, 2'd2, 4'd0, 32'h0000_4000, 32'h1234_5678);
        drive(1, 1'b1, 1'b0, 2'd2, 4'd0, 32'h0000_5000, 32'h0);
        #1 chk("t5_both_addr_ok", 32'(port_addr_ok), 32'h3);
        tick();
        port_req = '0;
        #1;
        chk("t5_valids", 32'({arvalid, awvalid, wvalid}), 32'h7);
        chk("t5_wstrb", 32'(wstrb), 32'hF);
        awready = 1'b1; arready = 1'b1;
        tick();
        awready = 1'b0; arready = 1'b0;
        #1 chk("t5_aw_first", 32'({awvalid, wvalid, bready}), 32'h2);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        #1 chk("t5_w_done", 32'({awvalid, wvalid, bready}), 32'h1);
        rvalid = 1'b1; rlast = 1'b1; bvalid = 1'b1;
        #1 chk("t5_dual_data_ok", 32'(port_data_ok), 32'h3);
        tick();
        rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0;

        // Half-word write, W before AW
        drive(0, 1'b1, 1'b1, 2'd1, 4'd0, 32'h0000_4006, 32'hBEEF_0000);
        #1 chk("t5b_addr_ok", 32'(port_addr_ok), 32'h1);
        tick();
        port_req[0] = 1'b0;
        wready = 1'b1;
        #1;
        chk("t5b_wstrb",  32'(wstrb),  32'hC);
        chk("t5b_awsize", 32'(awsize), 32'd1);
        tick();
        wready = 1'b0;
        #1 chk("t5b_w_first", 32'({awvalid, wvalid, bready}), 32'h4);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        #1 chk("t5b_aw_done", 32'({awvalid, wvalid, bready}), 32'h1);
        bvalid = 1'b1;
        #1 chk("t5b_b_data_ok", 32'(port_data_ok), 32'h1);
        tick();
        bvalid = 1'b0;

        // SLVERR beat sets bus_err; reset mid-burst clears everything
        drive(1, 1'b1, 1'b0, 2'd2, 4'd3, 32'h0000_6000, 32'h0);
        #1 chk("t6_addr_ok", 32'(port_addr_ok), 32'h2);
        tick();
        port_req[1] = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rresp = 2'b10; rlast = 1'b0;
        #1;
        chk("t6_err_beat_data_ok", 32'(port_data_ok), 32'h2);
        chk("t6_bus_err_before", 32'(bus_err), 32'd0);
        tick();
        rresp = 2'b00;
        #1;
        chk("t6_bus_err_set", 32'(bus_err), 32'd1);
        tick();
        #1 chk("t6_bus_err_sticky", 32'(bus_err), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_bus_err", 32'(bus_err), 32'd0);
        chk("t6_rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'h0);
        chk("t6_rst_data_ok", 32'(port_data_ok), 32'h0);
        tick();
        aresetn = 1'b1;
        #1;
        chk("t6_no_stray_data_ok", 32'(port_data_ok), 32'h0);
        chk("t6_no_addr_ok", 32'(port_addr_ok), 32'h0);
        tick();
        rvalid = 1'b0;
        drive(0, 1'b1, 1'b0, 2'd2, 4'd0, 32'h0000_7000, 32'h0);
        #1 chk("t6_idle_after_rst", 32'(port_addr_ok), 32'h1);
        tick();
        port_req = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
